// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
// Plays a melody from a small note table on a downstream square-wave tone
// generator. Each table entry holds a half-period count (0 = rest), a duration
// in ticks (0 = skip) and an end-of-melody flag. A prescaler turns the input
// clock into duration ticks. The sequencer supports an optional silent gap
// between notes, looping and abort.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_half_period/wr_dur/wr_last
//                      table write port (dropped while busy)
//   start              pulse: play from entry 0 (ignored while busy)
//   stop               abort playback, wins over start
//   loop               sampled at end of melody: restart at entry 0
//   tone_en            enable to the tone generator
//   tone_half_period   half-period to the tone generator
//   note_idx           index of the entry currently loaded
//   busy               high whenever not idle
//   done               one-cycle pulse on natural completion
// -----------------------------------------------------------------------------
module tone_sequencer #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int TICK_HZ   = 1_000,
    parameter int DEPTH     = 16,
    parameter int HP_W      = 16,
    parameter int DUR_W     = 12,
    parameter int GAP_TICKS = 10,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [HP_W-1:0]  wr_half_period,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic             wr_last,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic             tone_en,
    output logic [HP_W-1:0]  tone_half_period,
    output logic [AW-1:0]    note_idx,
    output logic             busy,
    output logic             done
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     idx_reg, idx_next;
    logic [HP_W-1:0]   hp_reg, hp_next;
    logic              en_reg, en_next;
    logic              done_reg, done_next;
    logic [PW-1:0]     presc_reg, presc_next;
    logic [DUR_W-1:0]  dur_reg, dur_next;
    logic [DUR_W-1:0]  gap_reg, gap_next;

    // Note table: plain storage, never reset so a melody survives rst_n.
    logic [HP_W-1:0]   hp_mem   [DEPTH];
    logic [DUR_W-1:0]  dur_mem  [DEPTH];
    logic              last_mem [DEPTH];

    logic              wr_ok;
    assign wr_ok = wr_en && (state_reg == IDLE);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (wr_ok && (wr_addr == AW'(gi))) begin
                    hp_mem[gi]   <= wr_half_period;
                    dur_mem[gi]  <= wr_dur;
                    last_mem[gi] <= wr_last;
                end
            end
        end
    endgenerate

    // Asynchronous read so LOAD completes in one cycle and sees a write
    // made on the same edge that accepted start.
    logic [HP_W-1:0]   rd_hp;
    logic [DUR_W-1:0]  rd_dur;
    logic              rd_last;
    assign rd_hp   = hp_mem[idx_reg];
    assign rd_dur  = dur_mem[idx_reg];
    assign rd_last = last_mem[idx_reg];

    logic tick;
    logic at_end;
    assign tick   = (presc_reg == PW'(TICK_DIV - 1));
    assign at_end = rd_last || (idx_reg == AW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            hp_reg    <= '0;
            en_reg    <= 1'b0;
            done_reg  <= 1'b0;
            presc_reg <= '0;
            dur_reg   <= '0;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            hp_reg    <= hp_next;
            en_reg    <= en_next;
            done_reg  <= done_next;
            presc_reg <= presc_next;
            dur_reg   <= dur_next;
            gap_reg   <= gap_next;
        end
    end

    logic advance;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        hp_next    = hp_reg;
        en_next    = en_reg;
        done_next  = 1'b0;
        presc_next = presc_reg;
        dur_next   = dur_reg;
        gap_next   = gap_reg;
        advance    = 1'b0;

        if ((state_reg == PLAY) || (state_reg == GAP)) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            LOAD: begin
                dur_next   = rd_dur;
                hp_next    = rd_hp;
                en_next    = (rd_hp != '0) && (rd_dur != '0);
                presc_next = '0;
                if (rd_dur == '0) begin
                    advance = 1'b1;      // zero-length entry: skip directly
                end else begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    dur_next = dur_reg - DUR_W'(1);
                    if (dur_reg == DUR_W'(1)) begin
                        en_next = 1'b0;
                        if (GAP_TICKS > 0) begin
                            state_next = GAP;
                            gap_next   = DUR_W'(GAP_TICKS);
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    gap_next = gap_reg - DUR_W'(1);
                    if (gap_reg == DUR_W'(1)) begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Move to the following entry, restart, or finish.
        if (advance) begin
            if (!at_end) begin
                idx_next   = idx_reg + AW'(1);
                state_next = LOAD;
            end else if (loop) begin
                idx_next   = '0;
                state_next = LOAD;
            end else begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end

        // Abort overrides everything, including a completion on this edge.
        if (stop) begin
            state_next = IDLE;
            en_next    = 1'b0;
            idx_next   = '0;
            done_next  = 1'b0;
        end
    end

    assign tone_en          = en_reg;
    assign tone_half_period = hp_reg;
    assign note_idx         = idx_reg;
    assign busy             = (state_reg != IDLE);
    assign done             = done_reg;

endmodule
